// File: rtl/amba_axi_read_if.sv
// Bus bundle for the AAC AXI3 read master: core request/stream side plus AR and R channels.
// The master modport is the read master's view; slave is the core + memory side.
interface amba_axi_read_if;
  logic [31:0] aacaddr;
  logic [3:0]  aaclen;
  logic        aacreq;
  logic        aacbusy;
  logic [31:0] aacdata;
  logic        aacdatavalid;
  logic        aacdatalast;
  logic        aacerr;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  aacaddr, aaclen, aacreq,
    output aacbusy, aacdata, aacdatavalid, aacdatalast, aacerr,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output aacaddr, aaclen, aacreq,
    input  aacbusy, aacdata, aacdatavalid, aacdatalast, aacerr,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/amba_axi_read.sv
// AXI3 read master: one INCR burst per core request, R beats forwarded as a registered
// valid/data/last stream with a sticky error flag for slave errors and rlast mismatches.
//
// state | meaning
// IDLE  | waiting for aacreq; rejects bursts crossing a 4 KB page
// ADDR  | arvalid high, araddr/arlen held until arready
// DATA  | rready high, forwarding beats (or dropping surplus beats after a missing rlast)
module amba_axi_read #(
  parameter logic [3:0] RID_VALUE = 4'b0000
) (
  input  logic aclk,
  input  logic aresetn,
  amba_axi_read_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arlen_q, arlen_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic [31:0] data_q, data_d;
  logic        dvalid_q, dvalid_d;
  logic        dlast_q, dlast_d;
  logic        err_q, err_d;

  logic [10:0] end_word;
  logic        crosses_4k;
  logic        r_hs;
  logic        beat_bad;

  // Last word index of the burst within its 4 KB page; beyond 1023 the burst leaves the page.
  assign end_word   = {1'b0, bus.aacaddr[11:2]} + {7'd0, bus.aaclen};
  assign crosses_4k = (end_word > 11'd1023);
  assign r_hs       = bus.rvalid && (state_q == ST_DATA);
  assign beat_bad   = bus.rresp[1] || (bus.rid != RID_VALUE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      araddr_q <= 32'd0;
      arlen_q  <= 4'd0;
      cnt_q    <= 4'd0;
      drop_q   <= 1'b0;
      data_q   <= 32'd0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;
    data_d   = data_q;
    dvalid_d = 1'b0;
    dlast_d  = 1'b0;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.aacreq) begin
          if (crosses_4k) begin
            err_d = 1'b1;
          end else begin
            araddr_d = {bus.aacaddr[31:2], 2'b00};
            arlen_d  = bus.aaclen;
            cnt_d    = bus.aaclen;
            err_d    = 1'b0;
            drop_d   = 1'b0;
            state_d  = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        if (bus.arready) state_d = ST_DATA;
      end

      ST_DATA: begin
        if (r_hs) begin
          if (drop_q) begin
            // Surplus beats after a missing rlast are swallowed until the slave ends the burst.
            if (bus.rlast) begin
              drop_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end else begin
            data_d   = bus.rdata;
            dvalid_d = 1'b1;
            cnt_d    = cnt_q - 4'd1;
            if (beat_bad) err_d = 1'b1;
            if (cnt_q == 4'd0) begin
              dlast_d = 1'b1;
              if (bus.rlast) begin
                state_d = ST_IDLE;
              end else begin
                err_d  = 1'b1;
                drop_d = 1'b1;
              end
            end else if (bus.rlast) begin
              err_d   = 1'b1;
              dlast_d = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.aacbusy      = (state_q != ST_IDLE);
  assign bus.aacdata      = data_q;
  assign bus.aacdatavalid = dvalid_q;
  assign bus.aacdatalast  = dlast_q;
  assign bus.aacerr       = err_q;

  assign bus.arid    = RID_VALUE;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = arlen_q;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0001;
  assign bus.arprot  = 3'b010;
  assign bus.arvalid = (state_q == ST_ADDR);
  assign bus.rready  = (state_q == ST_DATA);

endmodule

// File: tb/tb_amba_axi_read.sv
// Self-checking bench for amba_axi_read: a slave/core driver plus a burst-level reference
// model that predicts the forwarded beat stream from the beats the slave returns.
module tb_amba_axi_read;
  localparam logic [3:0] RID = 4'b0000;

  typedef struct packed {
    logic        last;
    logic        err;
    logic [31:0] data;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  amba_axi_read_if bus();

  amba_axi_read #(.RID_VALUE(RID)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail = 0;

  beat_t       obs_q[$];
  beat_t       exp_q[$];
  logic        exp_err;
  logic [31:0] tx_data[$];
  logic [1:0]  tx_resp[$];
  logic [3:0]  tx_id[$];

  int          ar_cycles;
  logic [31:0] ar_addr;
  logic [3:0]  ar_len;
  logic        ar_stable, busy_req, err_req, rready_ar, busy_end, timed_out;

  always @(negedge aclk)
    if (aresetn && bus.aacdatavalid) obs_q.push_back({bus.aacdatalast, bus.aacerr, bus.aacdata});

  task automatic idle_inputs();
    bus.aacreq  = 1'b0;
    bus.aacaddr = 32'd0;
    bus.aaclen  = 4'd0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'd0;
    bus.rresp   = 2'b00;
    bus.rid     = RID;
    bus.rlast   = 1'b0;
  endtask

  task automatic clear_tx();
    tx_data.delete(); tx_resp.delete(); tx_id.delete();
  endtask

  task automatic push_beat(input logic [31:0] d, input logic [1:0] r, input logic [3:0] id);
    tx_data.push_back(d); tx_resp.push_back(r); tx_id.push_back(id);
  endtask

  // Reference model: a burst of len+1 expected beats; whatever the slave actually returns is
  // forwarded up to the first of (its rlast, the expected count); errors accumulate per beat.
  task automatic build_expected(input logic [3:0] len);
    int fwd;
    logic e;
    exp_q.delete();
    e = 1'b0;
    fwd = (tx_data.size() < int'(len) + 1) ? tx_data.size() : int'(len) + 1;
    for (int i = 0; i < fwd; i++) begin
      if (tx_resp[i][1] || tx_id[i] != RID) e = 1'b1;
      if (i == fwd - 1 && tx_data.size() != int'(len) + 1) e = 1'b1;
      exp_q.push_back({(i == fwd - 1), e, tx_data[i]});
    end
    exp_err = e;
  endtask

  // Slave + core driver: issues the request, answers AR after ar_delay cycles, returns tx beats
  // with random gaps (rlast on the final one) and records what it observed along the way.
  task automatic drive_burst(input logic [31:0] addr, input logic [3:0] len,
                             input int ar_delay, input int gap);
    int t;
    obs_q.delete();
    timed_out = 1'b0; ar_cycles = 0; ar_stable = 1'b1;
    ar_addr = 32'hx; ar_len = 4'hx;
    @(negedge aclk);
    bus.aacaddr = addr; bus.aaclen = len; bus.aacreq = 1'b1;
    @(negedge aclk);
    bus.aacreq = 1'b0;
    busy_req = bus.aacbusy; err_req = bus.aacerr;
    t = 0;
    while (t < 100) begin
      if (bus.arvalid) begin
        if (ar_cycles == 0) begin
          ar_addr = bus.araddr; ar_len = bus.arlen;
        end else if (bus.araddr !== ar_addr || bus.arlen !== ar_len) begin
          ar_stable = 1'b0;
        end
        ar_cycles++;
        bus.arready = (ar_cycles > ar_delay);
      end else if (ar_cycles > 0) begin
        break;
      end
      @(negedge aclk);
      t++;
    end
    bus.arready = 1'b0;
    if (t >= 100) timed_out = 1'b1;
    rready_ar = bus.rready;
    for (int i = 0; i < tx_data.size() && !timed_out; i++) begin
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      repeat ($urandom_range(0, gap)) @(negedge aclk);
      t = 0;
      while (!bus.rready && t < 100) begin @(negedge aclk); t++; end
      if (t >= 100) timed_out = 1'b1;
      else begin
        bus.rvalid = 1'b1;
        bus.rdata  = tx_data[i];
        bus.rresp  = tx_resp[i];
        bus.rid    = tx_id[i];
        bus.rlast  = (i == tx_data.size() - 1);
        @(negedge aclk);
      end
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
    busy_end = bus.aacbusy;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    #23;
    n_checks++;
    if ({bus.aacbusy, bus.aacdata, bus.aacdatavalid, bus.aacdatalast, bus.aacerr,
         bus.araddr, bus.arlen, bus.arvalid, bus.rready} !== 74'd0) begin
      n_fail++;
      $display("FAIL reset_vars: got busy=%b data=%h v=%b l=%b err=%b araddr=%h arlen=%h arvalid=%b rready=%b want all zero",
               bus.aacbusy, bus.aacdata, bus.aacdatavalid, bus.aacdatalast, bus.aacerr,
               bus.araddr, bus.arlen, bus.arvalid, bus.rready);
    end
    n_checks++;
    if ({bus.arid, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot} !==
        {RID, 3'b010, 2'b01, 2'b00, 4'b0001, 3'b010}) begin
      n_fail++;
      $display("FAIL reset_consts: got id=%h size=%b burst=%b lock=%b cache=%b prot=%b",
               bus.arid, bus.arsize, bus.arburst, bus.arlock, bus.arcache, bus.arprot);
    end
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    clear_tx();
    push_beat(32'hCAFEBABE, 2'b00, RID);
    build_expected(4'd0);
    drive_burst(32'h0000_1000, 4'd0, 0, 0);
    n_checks++;
    if ({timed_out, busy_req, rready_ar, busy_end} !== 4'b0110) begin
      n_fail++;
      $display("FAIL single_ctrl: got to/busy_req/rready/busy_end=%b%b%b%b want 0110",
               timed_out, busy_req, rready_ar, busy_end);
    end
    n_checks++;
    if (ar_addr !== 32'h0000_1000 || ar_len !== 4'd0 || ar_cycles !== 1) begin
      n_fail++;
      $display("FAIL single_ar: got addr=%h len=%0d cycles=%0d want 00001000 0 1", ar_addr, ar_len, ar_cycles);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL single_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL single_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    n_checks++;
    if (bus.aacerr !== 1'b0) begin
      n_fail++;
      $display("FAIL single_err: got %b want 0", bus.aacerr);
    end
  endtask

  task automatic test_burst16();
    clear_tx();
    for (int i = 0; i < 16; i++) push_beat($urandom, 2'b00, RID);
    build_expected(4'd15);
    drive_burst(32'h0000_2000, 4'd15, 3, 3);
    n_checks++;
    if (ar_cycles !== 4 || ar_stable !== 1'b1 || ar_addr !== 32'h0000_2000 || ar_len !== 4'd15) begin
      n_fail++;
      $display("FAIL b16_ar: got cycles=%0d stable=%b addr=%h len=%0d want 4 1 00002000 15",
               ar_cycles, ar_stable, ar_addr, ar_len);
    end
    n_checks++;
    if ({timed_out, busy_end} !== 2'b00) begin
      n_fail++;
      $display("FAIL b16_end: got timeout=%b busy_end=%b want 0 0", timed_out, busy_end);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL b16_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL b16_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_4k_reject();
    logic seen_ar;
    @(negedge aclk);
    bus.aacaddr = 32'h0000_0FF8; bus.aaclen = 4'd3; bus.aacreq = 1'b1;
    @(negedge aclk);
    bus.aacreq = 1'b0;
    seen_ar = 1'b0;
    repeat (4) begin
      if (bus.arvalid || bus.aacbusy) seen_ar = 1'b1;
      @(negedge aclk);
    end
    n_checks++;
    if (seen_ar !== 1'b0 || bus.aacerr !== 1'b1) begin
      n_fail++;
      $display("FAIL reject: got ar_or_busy=%b err=%b want 0 1", seen_ar, bus.aacerr);
    end
    clear_tx();
    for (int i = 0; i < 4; i++) push_beat($urandom, 2'b00, RID);
    build_expected(4'd3);
    drive_burst(32'h0000_0FF0, 4'd3, 1, 1);
    n_checks++;
    if (err_req !== 1'b0 || busy_req !== 1'b1 || ar_addr !== 32'h0000_0FF0 || ar_len !== 4'd3) begin
      n_fail++;
      $display("FAIL edge_accept: got err=%b busy=%b addr=%h len=%0d want 0 1 00000ff0 3",
               err_req, busy_req, ar_addr, ar_len);
    end
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL edge_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL edge_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_slave_error();
    clear_tx();
    for (int i = 0; i < 4; i++) push_beat($urandom, (i == 1) ? 2'b10 : 2'b00, RID);
    build_expected(4'd3);
    drive_burst(32'h0000_3004, 4'd3, 0, 2);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL slverr_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL slverr_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    repeat (2) @(negedge aclk);
    n_checks++;
    if (bus.aacerr !== 1'b1 || busy_end !== 1'b0) begin
      n_fail++;
      $display("FAIL slverr_sticky: got err=%b busy_end=%b want 1 0", bus.aacerr, busy_end);
    end
  endtask

  task automatic test_last_mismatch();
    clear_tx();
    for (int i = 0; i < 2; i++) push_beat($urandom, 2'b00, RID);
    build_expected(4'd3);
    drive_burst(32'h0000_5000, 4'd3, 0, 1);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || busy_end !== 1'b0 || bus.aacerr !== 1'b1) begin
      n_fail++;
      $display("FAIL early_last: got beats=%0d busy_end=%b err=%b want %0d 0 1",
               obs_q.size(), busy_end, bus.aacerr, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL early_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
    clear_tx();
    for (int i = 0; i < 4; i++) push_beat($urandom, 2'b00, RID);
    build_expected(4'd1);
    drive_burst(32'h0000_6000, 4'd1, 0, 1);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || busy_end !== 1'b0 || bus.aacerr !== 1'b1 || timed_out !== 1'b0) begin
      n_fail++;
      $display("FAIL missing_last: got beats=%0d busy_end=%b err=%b timeout=%b want %0d 0 1 0",
               obs_q.size(), busy_end, bus.aacerr, timed_out, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL missing_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    bus.aacaddr = 32'h0000_4000; bus.aaclen = 4'd7; bus.aacreq = 1'b1;
    @(negedge aclk);
    bus.aacreq = 1'b0; bus.arready = 1'b1;
    @(negedge aclk);
    bus.arready = 1'b0;
    bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678; bus.rresp = 2'b10; bus.rid = RID;
    repeat (2) @(negedge aclk);
    n_checks++;
    if (bus.aacbusy !== 1'b1 || bus.aacerr !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got busy=%b err=%b want 1 1", bus.aacbusy, bus.aacerr);
    end
    #2 aresetn = 1'b0;
    #1;
    n_checks++;
    if ({bus.aacbusy, bus.aacdata, bus.aacdatavalid, bus.aacdatalast, bus.aacerr,
         bus.araddr, bus.arlen, bus.arvalid, bus.rready} !== 74'd0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b data=%h v=%b l=%b err=%b araddr=%h arlen=%h arvalid=%b rready=%b want all zero",
               bus.aacbusy, bus.aacdata, bus.aacdatavalid, bus.aacdatalast, bus.aacerr,
               bus.araddr, bus.arlen, bus.arvalid, bus.rready);
    end
    idle_inputs();
    @(negedge aclk);
    aresetn = 1'b1;
    clear_tx();
    for (int i = 0; i < 3; i++) push_beat($urandom, 2'b01, RID);
    build_expected(4'd2);
    drive_burst(32'h0000_4000, 4'd2, 1, 1);
    n_checks++;
    if (obs_q.size() !== exp_q.size() || busy_end !== 1'b0 || ar_addr !== 32'h0000_4000) begin
      n_fail++;
      $display("FAIL post_reset: got beats=%0d busy_end=%b addr=%h want %0d 0 00004000",
               obs_q.size(), busy_end, ar_addr, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL post_reset_beat%0d: got %h want %h", i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, addr;
    logic [9:0]  word;
    logic [3:0]  len;
    int          mode, nb;
    for (int it = 0; it < 8; it++) begin
      len  = 4'($urandom_range(0, 15));
      word = 10'($urandom_range(0, 1023 - int'(len)));
      r    = $urandom;
      addr = {r[31:12], word, r[1:0]};
      mode = $urandom_range(0, 2);
      nb = int'(len) + 1;
      if (mode == 1 && len > 0) nb = $urandom_range(1, int'(len));
      if (mode == 2) nb = int'(len) + 1 + $urandom_range(1, 3);
      clear_tx();
      for (int i = 0; i < nb; i++)
        push_beat($urandom, ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 4'b0101 : RID);
      build_expected(len);
      drive_burst(addr, len, $urandom_range(0, 3), 2);
      n_checks++;
      if (ar_addr !== {addr[31:2], 2'b00} || ar_len !== len || err_req !== 1'b0 || timed_out !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_ar: got addr=%h len=%0d err=%b to=%b want %h %0d 0 0",
                 it, ar_addr, ar_len, err_req, timed_out, {addr[31:2], 2'b00}, len);
      end
      n_checks++;
      if (obs_q.size() !== exp_q.size() || bus.aacerr !== exp_err || busy_end !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d_end: got beats=%0d err=%b busy_end=%b want %0d %b 0",
                 it, obs_q.size(), bus.aacerr, busy_end, exp_q.size(), exp_err);
      end
      foreach (exp_q[i]) begin
        n_checks++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_beat%0d: got %h want %h", it, i, (i < obs_q.size()) ? obs_q[i] : 'x, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst16();
    test_4k_reject();
    test_slave_error();
    test_last_mismatch();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/amba_axi_read.md
# amba_axi_read

AXI3 read master for the AAC decoder: it moves blocks of 32-bit words from system memory into the decoder core. It accepts one burst request at a time from the core, drives the AR channel, and collects the R beats. Each beat is forwarded to the core as a registered valid/data/last stream, and any protocol or slave errors are flagged. It sits beside the existing AXI write master on the same memory port.

## Interface
- RID_VALUE, 4'b0000, ID driven on arid and expected on rid
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  reset, asynchronous, active-low
- aacaddr  in  32  burst start byte address from core; bits [1:0] ignored
- aaclen  in  4  burst length minus one (1..16 beats)
- aacreq  in  1  request strobe; accepted only when aacbusy=0
- aacbusy  out  1  burst in progress
- aacdata  out  32  received word
- aacdatavalid  out  1  aacdata valid, one-cycle pulse per beat
- aacdatalast  out  1  marks final forwarded beat of burst
- aacerr  out  1  sticky error for current/last request
- arid  out  4  = RID_VALUE
- araddr  out  32  {aacaddr[31:2],2'b00}, registered
- arlen  out  4  registered aaclen
- arsize  out  3  constant 3'b010 (4 bytes)
- arburst  out  2  constant 2'b01 (INCR)
- arlock  out  2  constant 2'b00
- arcache  out  4  constant 4'b0001
- arprot  out  3  constant 3'b010
- arvalid  out  1  address valid
- arready  in  1  address ready
- rid  in  4  read ID
- rdata  in  32  read data
- rresp  in  2  read response
- rlast  in  1  final beat from slave
- rvalid  in  1  read valid
- rready  out  1  read ready

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: rready=0, arvalid=0.
  - On aacreq=1 with no 4 KB crossing: latch araddr/arlen, clear aacerr, load beat counter with aaclen, go to ADDR.
  - 4 KB check: 11-bit sum {1'b0,aacaddr[11:2]} + aaclen > 1023 means the burst crosses. The request is rejected: aacerr=1, stay IDLE, no AR issued, aacbusy stays 0.
- ADDR: arvalid=1, held with araddr/arlen stable until arready=1. Then go to DATA.
- DATA: rready=1. On each handshake (rvalid & rready):
  - Register rdata to aacdata and pulse aacdatavalid.
  - Decrement the beat counter.
  - Set aacerr if rresp[1]=1 (SLVERR/DECERR), or if rid≠RID_VALUE. The beat is still forwarded.
  - rlast=1 with counter≠0 (early last): set aacerr, assert aacdatalast on this beat, go to IDLE.
  - Counter=0 with rlast=0 (missing last): set aacerr, assert aacdatalast, keep rready=1 and drop further beats (no aacdatavalid) until an rlast handshake, then go to IDLE.
  - Counter=0 with rlast=1: normal end, aacdatalast=1, go to IDLE.
- aacbusy = (state≠IDLE).
- The core has no backpressure and must accept every aacdatavalid beat.
- aacreq while busy is ignored. It is not queued.
- Reset mid-burst: all state returns to IDLE immediately. Outstanding slave beats are not drained; the system must reset the slave too.

## Timing
- Reset values: aacbusy=0, aacdata=0, aacdatavalid=0, aacdatalast=0, aacerr=0, araddr=0, arlen=0, arvalid=0, rready=0. Constant outputs hold their constants. arid=RID_VALUE.
- Request latency: aacreq sampled at edge N → arvalid=1 and aacbusy=1 from edge N.
- AR handshake at edge M → arvalid=0 and rready=1 from edge M.
- R beat latency: handshake at edge K → aacdata/aacdatavalid valid from edge K for one cycle. aacdatalast coincides with the final forwarded beat.
- Final rlast handshake at edge L → aacbusy=0 and rready=0 from edge L. A new aacreq can be sampled at edge L+1.
- Back-to-back beats (rvalid held high) give aacdatavalid on consecutive cycles. There are no bubbles from the block.
- aacerr is set at the edge of the detecting event. It stays set until the next accepted request.

## Test plan
- Single beat: aacaddr=0x1000, aaclen=0, arready same cycle, one beat rdata=0xCAFEBABE, rlast=1 → araddr=0x1000, arlen=0, one aacdatavalid with aacdatalast=1, aacerr=0, aacbusy low after rlast.
- 16-beat burst: aacaddr=0x2000, aaclen=15, arready delayed 3 cycles, rvalid gapped randomly → arvalid held 4 cycles with stable address, 16 in-order words forwarded, aacdatalast only on 16th.
- 4 KB reject: aacaddr=0x0FF8, aaclen=3 → no arvalid, aacerr=1, aacbusy=0. Then aacaddr=0x0FF0, aaclen=3 → accepted, aacerr cleared.
- Slave error: 4-beat burst, rresp=2'b10 on beat 2 → all 4 beats forwarded, aacerr=1 from beat 2 and held.
- Last mismatches: aaclen=3 with rlast on beat 2 → aacdatalast on beat 2, aacerr=1, IDLE. aaclen=1 with rlast on beat 4 → beats 3–4 dropped, aacerr=1.
- Reset mid-burst: aresetn low during DATA → all outputs return to reset values asynchronously. After release, a new request completes normally.
